// File: rtl/hwpf_issue_arb_if.sv
// hwpf_issue_arb_if
//   Groups the prefetch-FIFO pop port and the dcache prefetch request port
//   used by hwpf_issue_arb.
//   master : issue arbiter side (drives pop pulse and dcache request)
//   slave  : environment side (FIFO + dcache)
//   fifo_read        pop pulse, one cycle
//   fifo_valid/addr  registered FIFO output, valid the cycle after fifo_read
//   dcache_req_*     prefetch request (valid/ready), addr is line aligned
//   dcache_rsp_valid prefetch completion, one pulse per accepted request
//
// Handshake: a request transfers on every cycle where dcache_req_valid and
// dcache_req_ready are both high. Once valid is raised, valid, addr and tid
// stay constant until that transfer (a flush is the only way to withdraw it);
// ready may be raised or lowered freely and never depends on anything else.
interface hwpf_issue_arb_if #(
    parameter int PADDR_W = 40,
    parameter int TID_W   = 4
);
    logic               fifo_read;
    logic               fifo_valid;
    logic [PADDR_W-1:0] fifo_addr;
    logic               dcache_req_valid;
    logic               dcache_req_ready;
    logic [PADDR_W-1:0] dcache_req_addr;
    logic [TID_W-1:0]   dcache_req_tid;
    logic               dcache_rsp_valid;

    modport master (
        output fifo_read,
        input  fifo_valid,
        input  fifo_addr,
        output dcache_req_valid,
        input  dcache_req_ready,
        output dcache_req_addr,
        output dcache_req_tid,
        input  dcache_rsp_valid
    );

    modport slave (
        input  fifo_read,
        output fifo_valid,
        output fifo_addr,
        input  dcache_req_valid,
        output dcache_req_ready,
        input  dcache_req_addr,
        input  dcache_req_tid,
        output dcache_rsp_valid
    );
endinterface

// File: rtl/hwpf_issue_arb.sv
// hwpf_issue_arb
//   Issue stage of the next-line prefetcher. Pops a line candidate from the
//   prefetch FIFO, line-aligns it, drops it if it hits the recently-issued
//   line filter, throttles on outstanding prefetches and offers it to the
//   dcache prefetch request port. No pop is started while a demand request
//   is pending.
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   flush_i           discard in-flight work, clear the filter
//   cpu_req_valid_i   demand request pending, blocks new pops
//   bus (master)      FIFO pop port and dcache request/response port
//   busy_o            FSM not idle or prefetches outstanding
//   issued_cnt_o      saturating count of accepted prefetches
//   dropped_cnt_o     saturating count of filter drops
//   dbg_state_o       current FSM state (IDLE=0, WAIT=1, CHECK=2, ISSUE=3)
// Configuration
//   HWPF_ISSUE_STATS_EN  defined: statistics counters implemented (not
//                        cleared by flush). Undefined: counters tied to 0.
module hwpf_issue_arb #(
    parameter int LANE_SIZE       = 64,
    parameter int PADDR_W         = 40,
    parameter int FILTER_DEPTH    = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TID_W           = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                cpu_req_valid_i,
    hwpf_issue_arb_if.master    bus,
    output logic                busy_o,
    output logic [31:0]         issued_cnt_o,
    output logic [31:0]         dropped_cnt_o,
    output logic [1:0]          dbg_state_o
);
    localparam int OFS    = $clog2(LANE_SIZE);
    localparam int LINE_W = PADDR_W - OFS;
    localparam int PTR_W  = $clog2(FILTER_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CHECK = 2'd2, ISSUE = 2'd3} state_t;

    state_t                  state_q;
    logic [LINE_W-1:0]       line_q;
    logic [TID_W-1:0]        tid_q;
    logic [TID_W-1:0]        outstanding_q;
    logic [LINE_W-1:0]       filter_line_q [FILTER_DEPTH];
    logic [FILTER_DEPTH-1:0] filter_vld_q;
    logic [PTR_W-1:0]        filter_ptr_q;

    logic filter_hit;
    logic pop_now;
    logic handshake;
    logic rsp_dec;
    logic unused_ofs;

    // Offset bits are discarded by line alignment.
    assign unused_ofs = ^bus.fifo_addr[OFS-1:0];

    always_comb begin
        filter_hit = 1'b0;
        for (int i = 0; i < FILTER_DEPTH; i++) begin
            if (filter_vld_q[i] && (filter_line_q[i] == line_q)) begin
                filter_hit = 1'b1;
            end
        end
    end

    // Pop is a combinational pulse from IDLE; gated by reset so every output
    // is 0 while reset is held.
    assign pop_now   = rst_ni && (state_q == IDLE) && !cpu_req_valid_i && !flush_i &&
                       (outstanding_q < TID_W'(MAX_OUTSTANDING));
    // A transfer in a flush cycle is discarded: no filter/tid/count update.
    assign handshake = (state_q == ISSUE) && bus.dcache_req_ready && !flush_i;
    // A response with nothing outstanding is ignored.
    assign rsp_dec   = bus.dcache_rsp_valid && (outstanding_q != '0);

    assign bus.fifo_read        = pop_now;
    assign bus.dcache_req_valid = (state_q == ISSUE);
    assign bus.dcache_req_addr  = {line_q, {OFS{1'b0}}};
    assign bus.dcache_req_tid   = tid_q;
    assign busy_o               = (state_q != IDLE) || (outstanding_q != '0);
    assign dbg_state_o          = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            line_q        <= '0;
            tid_q         <= '0;
            outstanding_q <= '0;
            filter_vld_q  <= '0;
            filter_ptr_q  <= '0;
            for (int i = 0; i < FILTER_DEPTH; i++) begin
                filter_line_q[i] <= '0;
            end
        end else begin
            // Outstanding and tid survive a flush: responses still return.
            if (handshake && !rsp_dec) begin
                outstanding_q <= outstanding_q + 1'b1;
            end else if (!handshake && rsp_dec) begin
                outstanding_q <= outstanding_q - 1'b1;
            end

            if (flush_i) begin
                state_q      <= IDLE;
                filter_vld_q <= '0;
                filter_ptr_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pop_now) begin
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.fifo_valid) begin
                            line_q  <= bus.fifo_addr[PADDR_W-1:OFS];
                            state_q <= CHECK;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    CHECK: begin
                        state_q <= filter_hit ? IDLE : ISSUE;
                    end
                    ISSUE: begin
                        if (bus.dcache_req_ready) begin
                            // Oldest entry is overwritten once the filter is full.
                            filter_line_q[filter_ptr_q] <= line_q;
                            filter_vld_q[filter_ptr_q]  <= 1'b1;
                            filter_ptr_q                <= filter_ptr_q + 1'b1;
                            tid_q                       <= tid_q + 1'b1;
                            state_q                     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef HWPF_ISSUE_STATS_EN
    logic drop_evt;
    logic [31:0] issued_cnt_q;
    logic [31:0] dropped_cnt_q;

    assign drop_evt = (state_q == CHECK) && filter_hit && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_cnt_q  <= '0;
            dropped_cnt_q <= '0;
        end else begin
            if (handshake && (issued_cnt_q != '1)) begin
                issued_cnt_q <= issued_cnt_q + 1'b1;
            end
            if (drop_evt && (dropped_cnt_q != '1)) begin
                dropped_cnt_q <= dropped_cnt_q + 1'b1;
            end
        end
    end

    assign issued_cnt_o  = issued_cnt_q;
    assign dropped_cnt_o = dropped_cnt_q;
`else
    assign issued_cnt_o  = '0;
    assign dropped_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hwpf_issue_arb.sv
// tb_hwpf_issue_arb
//   Bench for hwpf_issue_arb: directed scenarios plus a randomized run. A
//   transaction-level model (recently-issued line queue, outstanding count,
//   pending candidate) predicts every output on every cycle.
module tb_hwpf_issue_arb;
    localparam int PADDR_W = 40;
    localparam int TID_W   = 4;
    localparam int OFS     = 6;
    localparam int DEPTH   = 4;
    localparam int MAXO    = 2;
    localparam int LINE_W  = PADDR_W - OFS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic cpu_req = 1'b0;
    logic busy;
    logic [31:0] issued_cnt;
    logic [31:0] dropped_cnt;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    hwpf_issue_arb_if #(.PADDR_W(PADDR_W), .TID_W(TID_W)) bus ();

    hwpf_issue_arb #(
        .LANE_SIZE(64), .PADDR_W(PADDR_W), .FILTER_DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO), .TID_W(TID_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .cpu_req_valid_i(cpu_req),
        .bus(bus), .busy_o(busy), .issued_cnt_o(issued_cnt),
        .dropped_cnt_o(dropped_cnt), .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO source ----------------
    logic [PADDR_W-1:0] src_q[$];
    bit pop_seen = 1'b0;

    // ---------------- drivers ----------------
    task automatic drive(input bit cpu, input bit rdy, input bit rsp, input bit fl);
        @(posedge clk);
        #1;
        cpu_req              = cpu;
        bus.dcache_req_ready = rdy;
        bus.dcache_rsp_valid = rsp;
        flush                = fl;
        if (pop_seen && rst_n) begin
            if (src_q.size() > 0) begin
                bus.fifo_valid = 1'b1;
                bus.fifo_addr  = src_q.pop_front();
            end else begin
                bus.fifo_valid = 1'b0;
                bus.fifo_addr  = {8'hee, $urandom()};
            end
        end else begin
            bus.fifo_valid = 1'b0;
        end
    endtask

    task automatic run(input int n, input bit cpu, input bit rdy, input bit rsp, input bit fl);
        for (int i = 0; i < n; i++) drive(cpu, rdy, rsp, fl);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        bus.fifo_valid = 1'b0;
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    logic [LINE_W-1:0] m_recent[$];     // recently issued lines, oldest first
    bit                m_wait;          // popped last cycle, data arrives now
    bit                m_cand;          // candidate line awaiting filter decision
    logic [LINE_W-1:0] m_cand_line;
    bit                m_req;           // request being offered to dcache
    logic [LINE_W-1:0] m_req_line;
    int                m_out;
    int                m_tid;
    longint            m_issued;
    longint            m_dropped;

    // event recorders for literal checks
    int cyc = 0;
    int pop_cnt = 0;
    int hs_cnt = 0;
    int last_pop_cyc = 0;
    int valid_rise_cyc = 0;
    logic [PADDR_W-1:0] hs_addr;
    logic [TID_W-1:0]   hs_tid;
    bit prev_valid = 1'b0;

    task automatic model_reset();
        m_recent.delete();
        m_wait = 0; m_cand = 0; m_req = 0; m_out = 0; m_tid = 0;
        m_issued = 0; m_dropped = 0;
        m_cand_line = '0; m_req_line = '0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        bit exp_idle, exp_read, hit, hs, dec;
        cyc++;
        if (!rst_n) begin
            chk("rst_fifo_read", bus.fifo_read, 0);
            chk("rst_req_valid", bus.dcache_req_valid, 0);
            chk("rst_req_addr", bus.dcache_req_addr, 0);
            chk("rst_req_tid", bus.dcache_req_tid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_issued", issued_cnt, 0);
            chk("rst_dropped", dropped_cnt, 0);
            model_reset();
            pop_seen   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            exp_idle = !m_wait && !m_cand && !m_req;
            exp_read = exp_idle && !cpu_req && (m_out < MAXO) && !flush;
            chk("fifo_read", bus.fifo_read, exp_read);
            chk("req_valid", bus.dcache_req_valid, m_req);
            if (m_req) begin
                chk("req_addr", bus.dcache_req_addr, {m_req_line, 6'b0});
                chk("req_tid", bus.dcache_req_tid, m_tid);
            end
            chk("busy", busy, !exp_idle || (m_out != 0));
`ifdef HWPF_ISSUE_STATS_EN
            chk("issued_cnt", issued_cnt, m_issued);
            chk("dropped_cnt", dropped_cnt, m_dropped);
`else
            chk("issued_cnt", issued_cnt, 0);
            chk("dropped_cnt", dropped_cnt, 0);
`endif
            // event recording (from DUT, compared later against literals)
            pop_seen = bus.fifo_read;
            if (bus.fifo_read) begin pop_cnt++; last_pop_cyc = cyc; end
            if (bus.dcache_req_valid && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = bus.dcache_req_valid;
            if (bus.dcache_req_valid && bus.dcache_req_ready && !flush) begin
                hs_cnt++;
                hs_addr = bus.dcache_req_addr;
                hs_tid  = bus.dcache_req_tid;
            end

            // advance model by one cycle
            hs  = m_req && bus.dcache_req_ready && !flush;
            dec = bus.dcache_rsp_valid && (m_out > 0);
            if (flush) begin
                m_wait = 0; m_cand = 0; m_req = 0;
                m_recent.delete();
            end else if (m_req) begin
                if (bus.dcache_req_ready) begin
                    m_recent.push_back(m_req_line);
                    if (m_recent.size() > DEPTH) void'(m_recent.pop_front());
                    m_tid = (m_tid + 1) % (1 << TID_W);
                    if (m_issued < 64'hffff_ffff) m_issued++;
                    m_req = 0;
                end
            end else if (m_cand) begin
                hit = 0;
                foreach (m_recent[i]) if (m_recent[i] == m_cand_line) hit = 1;
                if (hit) begin
                    if (m_dropped < 64'hffff_ffff) m_dropped++;
                end else begin
                    m_req = 1;
                    m_req_line = m_cand_line;
                end
                m_cand = 0;
            end else if (m_wait) begin
                m_wait = 0;
                if (bus.fifo_valid) begin
                    m_cand = 1;
                    m_cand_line = bus.fifo_addr[PADDR_W-1:OFS];
                end
            end else if (exp_read) begin
                m_wait = 1;
            end
            m_out = m_out + (hs ? 1 : 0) - (dec ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int hs0, pops0;
        logic [PADDR_W-1:0] a;
        cpu_req = 1'b1;
        bus.fifo_valid = 1'b0;
        bus.fifo_addr = '0;
        bus.dcache_req_ready = 1'b0;
        bus.dcache_rsp_valid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single pop, latency and alignment
        src_q.push_back(40'h00_1000_0047);
        drive(0, 1, 0, 0);
        run(6, 1, 1, 0, 0);
        chk("t1_latency", valid_rise_cyc - last_pop_cyc, 3);
        chk("t1_addr", hs_addr, 40'h00_1000_0040);
        chk("t1_tid", hs_tid, 0);
        chk("t1_hs", hs_cnt, 1);
        @(negedge clk);
        chk("t1_busy_outstanding", busy, 1);
        drive(1, 1, 1, 0);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("t1_busy_drained", busy, 0);

        // 2: duplicate line dropped
        hs0 = hs_cnt;
        src_q.push_back(40'h00_2000_0000);
        src_q.push_back(40'h00_2000_0010);
        run(12, 0, 1, 0, 0);
        run(2, 1, 1, 0, 0);
        chk("t2_hs", hs_cnt - hs0, 1);
`ifdef HWPF_ISSUE_STATS_EN
        chk("t2_dropped", dropped_cnt, 1);
`endif
        run(2, 1, 1, 1, 0);

        // 3: outstanding throttle
        hs0 = hs_cnt;
        src_q.push_back(40'h00_3000_0000);
        src_q.push_back(40'h00_3000_0040);
        src_q.push_back(40'h00_3000_0080);
        run(20, 0, 1, 0, 0);
        chk("t3_two_issued", hs_cnt - hs0, 2);
        pops0 = pop_cnt;
        run(5, 0, 1, 0, 0);
        chk("t3_no_pop", pop_cnt - pops0, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("t3_pop_resumes", bus.fifo_read, 1);
        run(8, 1, 1, 0, 0);
        chk("t3_three_issued", hs_cnt - hs0, 3);
        run(3, 1, 1, 1, 0);

        // 4: backpressure with demand traffic pending
        hs0 = hs_cnt;
        src_q.push_back(40'h00_4000_0000);
        drive(0, 0, 0, 0);
        run(2, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0);
            @(negedge clk);
            chk("t4_valid_held", bus.dcache_req_valid, 1);
            chk("t4_addr_held", bus.dcache_req_addr, 40'h00_4000_0000);
            chk("t4_tid_held", bus.dcache_req_tid, 5);
        end
        drive(1, 1, 0, 0);
        run(2, 1, 1, 0, 0);
        chk("t4_single_hs", hs_cnt - hs0, 1);
        run(2, 1, 1, 1, 0);

        // 5: flush while issuing, then same line re-issued
        hs0 = hs_cnt;
        src_q.push_back(40'h00_5000_0000);
        drive(0, 0, 0, 0);
        run(3, 1, 0, 0, 0);
        drive(1, 1, 0, 1);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("t5_valid_dropped", bus.dcache_req_valid, 0);
        chk("t5_no_hs", hs_cnt - hs0, 0);
        src_q.push_back(40'h00_5000_0010);
        drive(0, 1, 0, 0);
        run(6, 1, 1, 0, 0);
        chk("t5_reissued", hs_cnt - hs0, 1);
        chk("t5_tid", hs_tid, 6);
        chk("t5_addr", hs_addr, 40'h00_5000_0000);
        run(2, 1, 1, 1, 0);

        // 6: filter eviction, handshake and response in the same cycle
        hs0 = hs_cnt;
        for (int k = 0; k < 5; k++) begin
            a = 40'h00_6000_0000 + 40'(k * 64);
            src_q.push_back(a);
        end
        src_q.push_back(40'h00_6000_0008);
        run(40, 0, 1, 1, 0);
        chk("t6_evicted_reissue", hs_cnt - hs0, 6);
        chk("t6_last_addr", hs_addr, 40'h00_6000_0000);
        run(3, 1, 1, 1, 0);

        // randomized run with flushes and one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(2);
            if (src_q.size() < 2 && $urandom_range(0, 2) == 0) begin
                a = 40'h07_0000_0000 | 40'($urandom_range(0, 7) << 6) | 40'($urandom_range(0, 63));
                src_q.push_back(a);
            end
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0);
        end
        run(3, 1, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
